// File: rtl/xgriscv_defines.sv
// rtl/xgriscv_defines.sv - shared xgriscv constants, fetch FSM encodings and the fetch entry type
//   XLEN           : data/address width
//   NOP_INSTR      : addi x0,x0,0, presented when no instruction is valid
//   FETCH_*        : fetch FSM state encodings
//   fetch_entry_t  : {pc, instr} pair carried through the fetch FIFO
package xgriscv_defines;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [1:0] FETCH_IDLE    = 2'd0;
  localparam logic [1:0] FETCH_WAIT    = 2'd1;
  localparam logic [1:0] FETCH_DISCARD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/xgr_fetch_fifo.sv
// rtl/xgr_fetch_fifo.sv - synchronous FIFO of {pc, instr} fetch entries with flush
//   clk, reset    : clock, asynchronous active-high reset
//   push/push_data: write one entry (ignored when full and not popping)
//   pop           : advance the head (ignored when empty)
//   flush         : empty the FIFO at the edge; dominates push and pop
//   head_data     : entry at the head, valid when head_valid
//   count         : number of stored entries, 0..DEPTH
module xgr_fetch_fifo
  import xgriscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == DEPTH_C);
  assign do_pop     = pop && head_valid;
  // A simultaneous pop frees the slot being written, so a full FIFO may still accept.
  assign do_push    = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing is readable until count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/xgr_fetch_buf.sv
// rtl/xgr_fetch_buf.sv - instruction fetch front end: fetch PC, imem request FSM, fetch FIFO to decode
//   Optional build macro XGR_FETCH_BYPASS_EN: forwards a response straight to decode when the FIFO is empty.
//   clk, reset                 : clock, asynchronous active-high reset
//   imem_req/imem_addr/gnt     : word fetch request (combinational) at the fetch PC
//   imem_rvalid/imem_rdata     : fetch response, one per granted request
//   redirect_valid/redirect_pc : taken branch/jump from EX; flushes and re-targets fetch
//   id_valid/id_instr/id_pc    : head of the fetch queue towards IF/ID (NOP / 0 when invalid)
//   id_ready                   : decode consumes the head this cycle
module xgr_fetch_buf
  import xgriscv_defines::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   fifo_count;
  logic            fifo_valid;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            issue;
  logic            resp_in_wait;
  logic            bypass;

  // Held low during reset so the request port shows its reset value asynchronously.
  assign imem_req     = !reset && (state == FETCH_IDLE) && (fifo_count < DEPTH_C) && !redirect_valid;
  assign imem_addr    = pc;
  assign issue        = imem_req && imem_gnt;
  assign resp_in_wait = (state == FETCH_WAIT) && imem_rvalid;

`ifdef XGR_FETCH_BYPASS_EN
  assign bypass = !fifo_valid && resp_in_wait && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately must not also land in the FIFO.
  assign fifo_push  = resp_in_wait && !redirect_valid && !(bypass && id_ready);
  assign fifo_pop   = fifo_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: pc, instr: imem_rdata};

  xgr_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign id_valid = fifo_valid || bypass;

  always_comb begin
    id_instr = NOP_INSTR;
    id_pc    = '0;
    if (fifo_valid) begin
      id_instr = fifo_head.instr;
      id_pc    = fifo_head.pc;
    end else if (bypass) begin
      id_instr = imem_rdata;
      id_pc    = pc;
    end
  end

  // A response arriving in the redirect cycle is simply dropped, so WAIT only
  // enters DISCARD when the stale response is still in flight. DISCARD leaves
  // on its one response even if another redirect lands in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:    if (issue) state_nxt = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_rvalid)         state_nxt = FETCH_IDLE;
        else if (redirect_valid) state_nxt = FETCH_DISCARD;
      end
      FETCH_DISCARD: if (imem_rvalid) state_nxt = FETCH_IDLE;
      default:       state_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid)    pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (resp_in_wait) pc <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_xgr_fetch_buf.sv
// tb/tb_xgr_fetch_buf.sv - directed self-checking bench for xgr_fetch_buf with a latency-programmable imem model
module tb_xgr_fetch_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  int checks;
  int errors;

  int          lat;
  int          delay;
  logic        pending;
  logic [31:0] p_addr;
  logic        use_ovr;
  logic [31:0] ovr;
  logic [31:0] fires[$];

  xgr_fetch_buf dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A50013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request/response handshake before the edge, then
  // advance the memory model and drive its response after the edge.
  task automatic tick();
    logic        fire;
    logic        took;
    logic [31:0] fa;
    @(negedge clk);
    fire = imem_req && imem_gnt;
    fa   = imem_addr;
    took = imem_rvalid;
    @(posedge clk);
    #1;
    if (took) begin
      pending = 1'b0;
      use_ovr = 1'b0;
    end
    if (fire) begin
      pending = 1'b1;
      p_addr  = fa;
      delay   = lat - 1;
      fires.push_back(fa);
    end else if (pending && delay > 0) begin
      delay--;
    end
    imem_rvalid = pending && (delay == 0);
    imem_rdata  = imem_rvalid ? (use_ovr ? ovr : mem_word(p_addr)) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    pending        = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    use_ovr        = 1'b0;
    redirect_valid = 1'b0;
    fires.delete();
    #1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    lat = 1; delay = 0; pending = 0; p_addr = 0; use_ovr = 0; ovr = 0;
    reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_req",   {31'h0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc",    id_pc, 32'h0);
    reset = 1'b0;
    #1;
    chk("first_req",  {31'h0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming with decode always ready: 0,4,8,12 at most 2 cycles apart
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!id_valid && n < 3) begin tick(); n++; end
      chk("stream_valid", {31'h0, id_valid}, 32'd1);
      chk("stream_pc",    id_pc, 32'(i * 4));
      chk("stream_instr", id_instr, mem_word(32'(i * 4)));
      tick();
    end

    // Fill to DEPTH with decode stalled, then drain
    do_reset();
    id_ready = 1'b0;
    repeat (20) tick();
    chk("full_nreq", 32'(fires.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("full_addr", (i < fires.size()) ? fires[i] : 32'hFFFFFFFF, 32'(i * 4));
    chk("full_req_low", {31'h0, imem_req}, 32'd0);
    fires.delete();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc",    id_pc, 32'(i * 4));
      chk("drain_instr", id_instr, mem_word(32'(i * 4)));
      tick();
    end
    chk("resume_addr", (fires.size() > 0) ? fires[0] : 32'hFFFFFFFF, 32'd16);

    // Redirect while waiting on addr 8; the late DEADBEEF response is dropped
    do_reset();
    id_ready = 1'b0;
    lat = 4;
    n = 0;
    while (fires.size() < 3 && n < 40) begin tick(); n++; end
    chk("rd_wait_addr", (fires.size() == 3) ? fires[2] : 32'hFFFFFFFF, 32'h8);
    chk("rd_pre_valid", {31'h0, id_valid}, 32'd1);
    use_ovr = 1'b1; ovr = 32'hDEADBEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("rd_no_req", {31'h0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_flush",       {31'h0, id_valid}, 32'd0);
    chk("rd_discard_req", {31'h0, imem_req}, 32'd0);
    fires.delete();
    n = 0;
    while (fires.size() < 1 && n < 12) begin tick(); n++; end
    chk("rd_new_addr", (fires.size() > 0) ? fires[0] : 32'hFFFFFFFF, 32'h100);
    chk("rd_dropped",  {31'h0, id_valid}, 32'd0);

    // Redirect target is word aligned (0x203 -> 0x200)
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("align_addr", imem_addr, 32'h200);
    fires.delete();
    n = 0;
    while (fires.size() < 1 && n < 12) begin tick(); n++; end
    chk("align_fire", (fires.size() > 0) ? fires[0] : 32'hFFFFFFFF, 32'h200);

    // Redirect coinciding with the response, then PC wrap at 0xFFFFFFFC
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_pc",      imem_addr, 32'hFFFFFFFC);
    chk("wrap_dropped", {31'h0, id_valid}, 32'd0);
    redirect_valid = 1'b1;
    #1;
    chk("idle_redir_noreq", {31'h0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    fires.delete();
    n = 0;
    while (fires.size() < 2 && n < 12) begin tick(); n++; end
    chk("wrap_first", (fires.size() > 0) ? fires[0] : 32'h1, 32'hFFFFFFFC);
    chk("wrap_next",  (fires.size() > 1) ? fires[1] : 32'h1, 32'h0);
    chk("wrap_head_pc",    id_pc, 32'hFFFFFFFC);
    chk("wrap_head_instr", id_instr, mem_word(32'hFFFFFFFC));

    // Asynchronous reset in WAIT with two entries buffered
    do_reset();
    id_ready = 1'b0;
    lat = 2;
    n = 0;
    while (fires.size() < 3 && n < 40) begin tick(); n++; end
    chk("ar_pre_valid", {31'h0, id_valid}, 32'd1);
    chk("ar_pre_pc",    id_pc, 32'h0);
    reset = 1'b1;
    #1;
    chk("ar_req",   {31'h0, imem_req}, 32'd0);
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_valid", {31'h0, id_valid}, 32'd0);
    chk("ar_instr", id_instr, NOP);
    chk("ar_pc",    id_pc, 32'h0);
    pending = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; fires.delete();
    tick();
    reset = 1'b0;
    #1;
    chk("ar_next_req",   {31'h0, imem_req}, 32'd1);
    chk("ar_next_addr",  imem_addr, 32'h0);
    chk("ar_next_valid", {31'h0, id_valid}, 32'd0);

`ifdef XGR_FETCH_BYPASS_EN
    // Zero-latency bypass into decode; the consumed word is never stored
    do_reset();
    id_ready = 1'b1;
    lat = 1;
    tick();
    chk("byp_valid", {31'h0, id_valid}, 32'd1);
    chk("byp_pc",    id_pc, 32'h0);
    chk("byp_instr", id_instr, mem_word(32'h0));
    tick();
    chk("byp_not_stored", {31'h0, id_valid}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
